matrix_result_reader: RTL and testbench

Drains the result matrix produced by the matrix multiplier core after `matrix_shifter` signals completion. On a `done` strobe it snapshots the flat C matrix and active dimensions, then streams only the active N×M elements out, row-major, over a valid/ready word interface toward the bus/register side. This makes it the read-out end of the `c_flat_out` path that the shifter and systolic array write.

---
 rtl/matrix_result_reader.sv | 182 ++++++++++++++++++
 tb/tb_matrix_result_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_reader.sv
// Result-matrix read-out: snapshots C on done_i and streams the active (N+1)x(M+1) elements row-major.
// Optional feature macro: MATRIX_READER_ROW_LAST_EN (adds row_last_o).
module matrix_result_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_n_i,
    input  logic                                                   done_i,
    input  logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] c_flat_in,
    input  logic [1:0]                                             N_i,
    input  logic [1:0]                                             M_i,
    input  logic                                                   ready_i,
    output logic [BUS_WIDTH-1:0]                                   data_o,
    output logic                                                   valid_o,
    output logic                                                   last_o,
    output logic                                                   busy_o,
    output logic                                                   rd_done_o,
    output logic                                                   overrun_o
`ifdef MATRIX_READER_ROW_LAST_EN
    ,
    output logic                                                   row_last_o
`endif
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int FLAT_W  = BUS_WIDTH * MAX_DIM * MAX_DIM;
    localparam int IDX_W   = $clog2(MAX_DIM * MAX_DIM);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                r_state;
    logic [FLAT_W-1:0]     r_snap;
    logic [1:0]            r_n;
    logic [1:0]            r_m;
    logic [1:0]            r_row;
    logic [1:0]            r_col;
    logic [BUS_WIDTH-1:0]  r_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_rd_done;
    logic                  r_overrun;
    logic                  r_row_last;

    state_t                w_state_nxt;
    logic [FLAT_W-1:0]     w_snap_nxt;
    logic [1:0]            w_n_nxt;
    logic [1:0]            w_m_nxt;
    logic [1:0]            w_row_nxt;
    logic [1:0]            w_col_nxt;
    logic [IDX_W-1:0]      w_idx;
    logic [BUS_WIDTH-1:0]  w_data_nxt;
    logic                  w_valid_nxt;
    logic                  w_last_nxt;
    logic                  w_row_last_nxt;
    logic                  w_rd_done_nxt;
    logic                  w_overrun_nxt;
    logic                  w_capture;
    logic                  w_advance;
    logic                  w_xfer;

    assign w_xfer = r_valid & ready_i;

    // Next-state decode: capture, advance, finish and overrun detection.
    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        w_rd_done_nxt = 1'b0;
        w_overrun_nxt = r_overrun;
        case (r_state)
            ST_IDLE: begin
                if (done_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (w_xfer && r_last) begin
                    w_rd_done_nxt = 1'b1;
                    // A done_i on the final transfer chains straight into the next snapshot.
                    if (done_i) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_advance = w_xfer;
                    if (done_i) begin
                        w_overrun_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = r_overrun;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: snapshot, row/col counters and the next registered output word.
    always_comb begin
        w_snap_nxt = w_capture ? c_flat_in : r_snap;
        w_n_nxt    = w_capture ? N_i : r_n;
        w_m_nxt    = w_capture ? M_i : r_m;
        w_row_nxt  = r_row;
        w_col_nxt  = r_col;
        if (w_capture) begin
            w_row_nxt = 2'd0;
            w_col_nxt = 2'd0;
        end else if (w_advance) begin
            if (r_col == r_m) begin
                w_col_nxt = 2'd0;
                w_row_nxt = r_row + 2'd1;
            end else begin
                w_col_nxt = r_col + 2'd1;
                w_row_nxt = r_row;
            end
        end else begin
            w_row_nxt = r_row;
            w_col_nxt = r_col;
        end
        w_valid_nxt    = (w_state_nxt == ST_STREAM);
        w_idx          = IDX_W'(w_row_nxt) * IDX_W'(MAX_DIM) + IDX_W'(w_col_nxt);
        w_data_nxt     = w_valid_nxt ? w_snap_nxt[w_idx*BUS_WIDTH +: BUS_WIDTH] : {BUS_WIDTH{1'b0}};
        w_last_nxt     = w_valid_nxt && (w_row_nxt == w_n_nxt) && (w_col_nxt == w_m_nxt);
        w_row_last_nxt = w_valid_nxt && (w_col_nxt == w_m_nxt);
    end

    // State, snapshot and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_snap     <= {FLAT_W{1'b0}};
            r_n        <= 2'd0;
            r_m        <= 2'd0;
            r_row      <= 2'd0;
            r_col      <= 2'd0;
            r_data     <= {BUS_WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_rd_done  <= 1'b0;
            r_overrun  <= 1'b0;
            r_row_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_snap     <= w_snap_nxt;
            r_n        <= w_n_nxt;
            r_m        <= w_m_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_last     <= w_last_nxt;
            r_rd_done  <= w_rd_done_nxt;
            r_overrun  <= w_overrun_nxt;
            r_row_last <= w_row_last_nxt;
        end
    end

    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign last_o    = r_last;
    assign busy_o    = r_valid;
    assign rd_done_o = r_rd_done;
    assign overrun_o = r_overrun;

`ifdef MATRIX_READER_ROW_LAST_EN
    assign row_last_o = r_row_last;
`else
    logic w_row_last_unused;
    assign w_row_last_unused = r_row_last;
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// Scoreboard bench for matrix_result_reader: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_matrix_result_reader;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         done_i;
    logic [511:0] c_flat_in;
    logic [1:0]   N_i;
    logic [1:0]   M_i;
    logic         ready_i;
    logic [31:0]  data_o;
    logic         valid_o;
    logic         last_o;
    logic         busy_o;
    logic         rd_done_o;
    logic         overrun_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;
    logic [32:0] exp_q[$];

    logic        stall_prev = 1'b0;
    logic [32:0] stall_word = 33'd0;

    matrix_result_reader dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .done_i    (done_i),
        .c_flat_in (c_flat_in),
        .N_i       (N_i),
        .M_i       (M_i),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .rd_done_o (rd_done_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: each accepted word is compared against the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (stall_prev && valid_o) begin
                n_checks++;
                if ({last_o, data_o} !== stall_word) begin
                    n_errors++;
                    $display("FAIL stall_hold: got last=%0b data=%h, required last=%0b data=%h",
                             last_o, data_o, stall_word[32], stall_word[31:0]);
                end
            end
            if (valid_o && ready_i) begin
                n_xfer++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_word: got data=%h, required no word", data_o);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({last_o, data_o} !== e) begin
                        n_errors++;
                        $display("FAIL word: got last=%0b data=%h, required last=%0b data=%h",
                                 last_o, data_o, e[32], e[31:0]);
                    end
                end
            end
            stall_prev = valid_o && !ready_i;
            stall_word = {last_o, data_o};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_seq(input int base);
        for (int k = 0; k < 16; k++) c_flat_in[k*32 +: 32] = 32'(base + k);
    endtask

    task automatic start(input logic [1:0] n, input logic [1:0] m);
        N_i    = n;
        M_i    = m;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    // Waits for the scoreboard to empty; optional 0,1,0,0,1 ready pattern.
    task automatic drain(input bit bp, output int cycles);
        logic [4:0] pat;
        pat = 5'b10010;
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            if (bp) ready_i = pat[i % 5];
            tick();
            cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
            exp_q.delete();
        end
        ready_i = 1'b1;
    endtask

    task automatic check_finish(input string name);
        check({name, "_rd_done"}, 32'(rd_done_o), 32'd1);
        check({name, "_valid_off"}, 32'(valid_o), 32'd0);
        check({name, "_busy_off"}, 32'(busy_o), 32'd0);
        tick();
        check({name, "_rd_done_pulse"}, 32'(rd_done_o), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_data"}, data_o, 32'd0);
        check({name, "_valid"}, 32'(valid_o), 32'd0);
        check({name, "_last"}, 32'(last_o), 32'd0);
        check({name, "_busy"}, 32'(busy_o), 32'd0);
        check({name, "_rd_done"}, 32'(rd_done_o), 32'd0);
        check({name, "_overrun"}, 32'(overrun_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int x0;
        rst_n_i   = 1'b0;
        done_i    = 1'b0;
        ready_i   = 1'b0;
        N_i       = 2'd0;
        M_i       = 2'd0;
        c_flat_in = 512'd0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst_n_i = 1'b1;
        tick();

        // Full 4x4 stream, ready always high.
        ready_i = 1'b1;
        set_seq(100);
        for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), 32'(100 + k)});
        start(2'd3, 2'd3);
        check("full_first_valid", 32'(valid_o), 32'd1);
        check("full_first_data", data_o, 32'd100);
        drain(1'b0, cyc);
        check("full_cycles", 32'(cyc), 32'd16);
        check_finish("full");

        // Partial 2x4 stream; element (2,0) must never appear.
        for (int k = 0; k < 16; k++) c_flat_in[k*32 +: 32] = 32'd1;
        c_flat_in[8*32 +: 32] = 32'hDEAD;
        for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), 32'd1});
        x0 = n_xfer;
        start(2'd1, 2'd3);
        drain(1'b0, cyc);
        check("partial_count", 32'(n_xfer - x0), 32'd8);
        check_finish("partial");

        // Backpressure on a 2x2 stream.
        set_seq(100);
        exp_q.push_back({1'b0, 32'd100});
        exp_q.push_back({1'b0, 32'd101});
        exp_q.push_back({1'b0, 32'd104});
        exp_q.push_back({1'b1, 32'd105});
        x0 = n_xfer;
        ready_i = 1'b0;
        start(2'd1, 2'd1);
        drain(1'b1, cyc);
        check("bp_count", 32'(n_xfer - x0), 32'd4);
        check_finish("bp");
        check("overrun_clear", 32'(overrun_o), 32'd0);

        // Overrun: a mid-stream done_i with new data and dims must be ignored.
        set_seq(100);
        exp_q.push_back({1'b0, 32'd100});
        exp_q.push_back({1'b0, 32'd101});
        exp_q.push_back({1'b0, 32'd104});
        exp_q.push_back({1'b1, 32'd105});
        start(2'd1, 2'd1);
        tick();
        for (int k = 0; k < 16; k++) c_flat_in[k*32 +: 32] = 32'hBAD;
        N_i    = 2'd3;
        M_i    = 2'd3;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check("overrun_set", 32'(overrun_o), 32'd1);
        drain(1'b0, cyc);
        check_finish("overrun");
        tick();
        check("overrun_sticky", 32'(overrun_o), 32'd1);

        // Back-to-back 1x1 snapshots: 7 then 9 with no gap.
        c_flat_in[31:0] = 32'd7;
        exp_q.push_back({1'b1, 32'd7});
        exp_q.push_back({1'b1, 32'd9});
        start(2'd0, 2'd0);
        check("b2b_first", data_o, 32'd7);
        check("b2b_first_last", 32'(last_o), 32'd1);
        c_flat_in[31:0] = 32'd9;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check("b2b_valid_held", 32'(valid_o), 32'd1);
        check("b2b_second", data_o, 32'd9);
        check("b2b_rd_done", 32'(rd_done_o), 32'd1);
        drain(1'b0, cyc);
        check_finish("b2b");

        // Mid-stream reset after the third transfer, then restart at (0,0).
        set_seq(100);
        exp_q.push_back({1'b0, 32'd100});
        exp_q.push_back({1'b0, 32'd101});
        exp_q.push_back({1'b0, 32'd102});
        start(2'd3, 2'd3);
        tick();
        tick();
        tick();
        check("rst_three_done", 32'(exp_q.size()), 32'd0);
        ready_i = 1'b0;
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        check_outputs_zero("midrst");
        tick();
        check("midrst_no_rd_done", 32'(rd_done_o), 32'd0);
        check("midrst_idle", 32'(valid_o), 32'd0);
        exp_q.delete();
        ready_i = 1'b1;
        set_seq(200);
        exp_q.push_back({1'b0, 32'd200});
        exp_q.push_back({1'b1, 32'd201});
        start(2'd0, 2'd1);
        check("restart_first", data_o, 32'd200);
        drain(1'b0, cyc);
        check_finish("restart");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
